// File: rtl/circle_point_gen_pkg.sv
// Shared types for the midpoint circle point generator.
// FSM state encoding and octant select constants.
package circle_point_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    STEP,
    DONE
  } state_e;

  localparam logic [2:0] OCT_0 = 3'd0;
  localparam logic [2:0] OCT_1 = 3'd1;
  localparam logic [2:0] OCT_2 = 3'd2;
  localparam logic [2:0] OCT_3 = 3'd3;
  localparam logic [2:0] OCT_4 = 3'd4;
  localparam logic [2:0] OCT_5 = 3'd5;
  localparam logic [2:0] OCT_6 = 3'd6;
  localparam logic [2:0] OCT_7 = 3'd7;

endpackage

// File: rtl/circle_octant_mux.sv
// Maps the first-octant offset (x,y) into one of eight
// symmetric points around the centre, modulo 2^W.
module circle_octant_mux
  import circle_point_gen_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [2:0]   oct,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y
);

  always_comb begin
    out_x = cx;
    out_y = cy;
    unique case (oct)
      OCT_0: begin out_x = cx + x; out_y = cy + y; end
      OCT_1: begin out_x = cx + y; out_y = cy + x; end
      OCT_2: begin out_x = cx - y; out_y = cy + x; end
      OCT_3: begin out_x = cx - x; out_y = cy + y; end
      OCT_4: begin out_x = cx - x; out_y = cy - y; end
      OCT_5: begin out_x = cx - y; out_y = cy - x; end
      OCT_6: begin out_x = cx + y; out_y = cy - x; end
      OCT_7: begin out_x = cx + x; out_y = cy - y; end
    endcase
  end

endmodule

// File: rtl/circle_point_gen.sv
// Midpoint circle walker: streams all 8-way symmetric points
// of a circle over a valid/ready port using add/sub/shift only.
module circle_point_gen
  import circle_point_gen_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  input  logic [W-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y
);

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_X = {{W{1'b0}}, 1'b1};
  localparam logic [W+1:0] ONE_E = {{(W+1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [W-1:0] cx_q, cx_d;
  logic [W-1:0] cy_q, cy_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [W+1:0] err_q, err_d;
  logic [2:0]   oct_q, oct_d;
  logic [W-1:0] ox_q, ox_d;
  logic [W-1:0] oy_q, oy_d;

  logic         err_neg;
  logic [W-1:0] y_inc;
  logic [W:0]   x_nxt;
  logic [W+1:0] y_ext;
  logic [W+1:0] x_ext;
  logic [W+1:0] diff;
  logic [W+1:0] delta;
  logic         more;

  // x_nxt carries an extra sign bit so r=0 terminates instead of wrapping
  always_comb begin
    err_neg = err_q[W+1];
    y_inc   = y_q + ONE_W;
    x_nxt   = err_neg ? {1'b0, x_q} : ({1'b0, x_q} - ONE_X);
    y_ext   = {2'b00, y_inc};
    x_ext   = {x_nxt[W], x_nxt};
    diff    = err_neg ? y_ext : (y_ext - x_ext);
    delta   = {diff[W:0], 1'b0} + ONE_E;
    more    = $signed(x_nxt) >= $signed({1'b0, y_inc});
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    oct_d   = oct_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cx_d    = cx;
          cy_d    = cy;
          x_d     = r;
          y_d     = '0;
          err_d   = ONE_E - {2'b00, r};
          oct_d   = OCT_0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          oct_d = oct_q + 3'd1;
          if (oct_q == OCT_7) state_d = STEP;
        end
      end
      STEP: begin
        y_d     = y_inc;
        x_d     = x_nxt[W-1:0];
        err_d   = err_q + delta;
        oct_d   = OCT_0;
        state_d = more ? EMIT : DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Point is computed from next-state values so the register
  // already holds it when EMIT is entered.
  circle_octant_mux #(.W(W)) u_mux (
    .cx    (cx_d),
    .cy    (cy_d),
    .x     (x_d),
    .y     (y_d),
    .oct   (oct_d),
    .out_x (ox_d),
    .out_y (oy_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
      oct_q   <= OCT_0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      oct_q   <= oct_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == EMIT);
  assign out_x     = ox_q;
  assign out_y     = oy_q;

endmodule

// File: tb/tb_circle_point_gen.sv
// Randomized bench for circle_point_gen against a
// plain-arithmetic midpoint circle model.
module tb_circle_point_gen;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] cx = '0;
  logic [W-1:0] cy = '0;
  logic [W-1:0] r = '0;
  logic         busy;
  logic         done;
  logic         out_valid;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  circle_point_gen #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cx        (cx),
    .cy        (cy),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [31:0] c_x, input logic [31:0] c_y,
                       input logic [31:0] r_in);
    longint x, y, err;
    logic [31:0] a, b;
    x = {32'd0, r_in};
    y = 0;
    err = 1 - x;
    exp_q.delete();
    do begin
      a = x[31:0];
      b = y[31:0];
      exp_q.push_back({c_x + a, c_y + b});
      exp_q.push_back({c_x + b, c_y + a});
      exp_q.push_back({c_x - b, c_y + a});
      exp_q.push_back({c_x - a, c_y + b});
      exp_q.push_back({c_x - a, c_y - b});
      exp_q.push_back({c_x - b, c_y - a});
      exp_q.push_back({c_x + b, c_y - a});
      exp_q.push_back({c_x + a, c_y - b});
      y = y + 1;
      if (err < 0) err = err + 2 * y + 1;
      else begin
        x = x - 1;
        err = err + 2 * (y - x) + 1;
      end
    end while (x >= y);
  endtask

  task automatic run_txn(input logic [31:0] c_x, input logic [31:0] c_y,
                         input logic [31:0] r_in, input int bp,
                         input int stall_at, input bit poke);
    int idx, cyc, stall;
    bit poked, held, rdy;
    logic [63:0] last;
    logic signed [31:0] dx, dy;
    longint d2;
    idx = 0; cyc = 0; stall = 0;
    poked = 0; held = 0; last = '0;
    build(c_x, c_y, r_in);
    got_q.delete();
    @(negedge clk);
    cx = c_x; cy = c_y; r = r_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("valid_rise", {63'd0, out_valid}, 64'd1);
    while (idx < exp_q.size() && cyc < 4000) begin
      if (held) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_point", {out_x, out_y}, last);
      end
      if (done) check("done_early", {63'd0, done}, 64'd0);
      start = 1'b0;
      if (poke && idx == 3 && !poked) begin
        start = 1'b1; cx = ~c_x; cy = ~c_y; r = r_in + 5; poked = 1;
      end
      rdy = ($urandom_range(99) >= bp);
      if (idx == stall_at && stall < 5) begin
        rdy = 0; stall++;
      end
      out_ready = rdy;
      held = out_valid && !rdy;
      last = {out_x, out_y};
      if (out_valid && rdy) begin
        got_q.push_back({out_x, out_y});
        check("point", {out_x, out_y}, exp_q[idx]);
        if (r_in == 3) begin
          dx = out_x - c_x;
          dy = out_y - c_y;
          d2 = longint'(dx) * dx + longint'(dy) * dy;
          check("r3_dist", {63'd0, (d2 >= 6 && d2 <= 12)}, 64'd1);
        end
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("count", 64'(idx), 64'(exp_q.size()));
    check("step_valid", {63'd0, out_valid}, 64'd0);
    check("step_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("done", {63'd0, done}, 64'd1);
    check("done_busy", {63'd0, busy}, 64'd1);
    check("done_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_done", {63'd0, done}, 64'd0);
  endtask

  initial begin
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_xy", {out_x, out_y}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(32'd5, 32'd5, 32'd0, 0, -1, 0);
    check("r0_n", 64'(got_q.size()), 64'd8);
    run_txn(32'd10, 32'd10, 32'd1, 0, -1, 0);
    check("r1_p0", got_q[0], {32'd11, 32'd10});
    check("r1_p7", got_q[7], {32'd11, 32'd10});
    run_txn(32'h100, 32'h100, 32'd3, 0, -1, 0);
    check("r3_n", 64'(got_q.size()), 64'd24);
    run_txn(32'd1000, 32'd2000, 32'd5, 0, 12, 0);
    run_txn(32'd0, 32'd0, 32'd1, 0, -1, 0);
    check("wrap_x3", {32'd0, got_q[3][63:32]}, 64'h0000_0000_FFFF_FFFF);
    check("wrap_y5", {32'd0, got_q[5][31:0]}, 64'h0000_0000_FFFF_FFFF);
    run_txn(32'd50, 32'd60, 32'd4, 20, -1, 1);

    @(negedge clk);
    cx = 32'd7; cy = 32'd9; r = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_xy", {out_x, out_y}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'd7, 32'd9, 32'd6, 0, -1, 0);

    for (int i = 0; i < 20; i++) begin
      run_txn($urandom, $urandom, $urandom_range(24), $urandom_range(50),
              $urandom_range(40), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
